// File: rtl/wca_dduc_pkg.sv
// Shared definitions for the DDUC/DUC sequencers: FSM state encoding,
// cfg register bit map and the default interpolation-rate width.
package wca_dduc_pkg;

    localparam int RATE_W_DEF  = 13;

    localparam int CFG_ACLR    = 1;
    localparam int CFG_BYP_CIC = 3;
    localparam int CFG_BYP_HBF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/wca_log2_enc.sv
// Combinational floor(log2) priority encoder; a zero input encodes as 0.
// Shared by the up- and down-converter sequencers.
module wca_log2_enc
    import wca_dduc_pkg::*;
#(
    parameter int IN_W = RATE_W_DEF
) (
    input  logic [IN_W-1:0] value,
    output logic [3:0]      log2
);

    always_comb begin
        log2 = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (value[i]) begin
                log2 = 4'(i);
            end
        end
    end

endmodule

// File: rtl/wca_duc_sequencer.sv
// DUC timing controller: CIC/baseband strobes, CORDIC phase, priming FSM, underrun.
// Optional saturating underrun counter output enabled by WCA_DUC_UNDERRUN_CNT_EN.
module wca_duc_sequencer
    import wca_dduc_pkg::*;
#(
    parameter int PRIME_CYCLES = 16,
    parameter int RATE_W       = RATE_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [7:0]        cfg,
    input  logic [RATE_W-1:0] rate_interp,
    input  logic              rate_interp_we,
    input  logic [31:0]       phase_inc,
    input  logic              phase_inc_we,
    input  logic              strobe_if,
    input  logic              bb_valid,
    output logic              strobe_cic,
    output logic              strobe_bb,
    output logic [31:0]       phase_cordic,
    output logic [3:0]        log2_rate,
    output logic              running,
`ifdef WCA_DUC_UNDERRUN_CNT_EN
    output logic              underrun,
    output logic [15:0]       underrun_cnt
`else
    output logic              underrun
`endif
);

    localparam int                 PRIME_W    = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_CYCLES - 1);
    localparam logic [RATE_W-1:0]  RATE_ONE   = RATE_W'(1);

    seq_state_e         state_q, state_d;
    logic [RATE_W-1:0]  pending_rate_q, pending_rate_d;
    logic [RATE_W-1:0]  active_rate_q, active_rate_d;
    logic [RATE_W-1:0]  cic_cnt_q, cic_cnt_d;
    logic [31:0]        pending_inc_q, pending_inc_d;
    logic [31:0]        active_inc_q, active_inc_d;
    logic [31:0]        phase_q, phase_d;
    logic [PRIME_W-1:0] prime_cnt_q, prime_cnt_d;
    logic [3:0]         log2_rate_q, log2_rate_d;
    logic               hb_ph_q, hb_ph_d;
    logic               strobe_cic_q, strobe_cic_d;
    logic               strobe_bb_q, strobe_bb_d;
    logic               underrun_q, underrun_d;

    logic              aclr, byp_cic, byp_hbf;
    logic              go, rate_upd, fire, underrun_evt;
    logic [RATE_W-1:0] eff_rate, eff_rate_next;
    logic              unused_cfg;

    assign aclr       = cfg[CFG_ACLR];
    assign byp_cic    = cfg[CFG_BYP_CIC];
    assign byp_hbf    = cfg[CFG_BYP_HBF];
    assign unused_cfg = ^{cfg[7:6], cfg[4], cfg[2], cfg[0]};

    // Gated with enable/aclr so strobes stop on the very clock the abort is seen.
    assign go       = (state_q != IDLE) && enable && !aclr;
    assign rate_upd = go && strobe_if && (cic_cnt_q == '0);
    assign fire     = go && strobe_if && ((cic_cnt_q == '0) || (eff_rate == RATE_ONE));

    assign active_rate_d = (!go || rate_upd) ? pending_rate_q : active_rate_q;
    assign eff_rate      = byp_cic ? RATE_ONE : active_rate_q;
    assign eff_rate_next = byp_cic ? RATE_ONE : active_rate_d;

    assign underrun_evt = (state_q == RUN) && strobe_bb_q && !bb_valid;

    wca_log2_enc #(.IN_W(RATE_W)) u_log2_enc (
        .value (eff_rate_next),
        .log2  (log2_rate_d)
    );

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable || aclr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = PRIME;
                PRIME:   if (strobe_if && (prime_cnt_q == PRIME_LAST)) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state_q == RUN);
    end

    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        pending_rate_d = pending_rate_q;
        if (rate_interp_we) begin
            pending_rate_d = (rate_interp < RATE_W'(2)) ? RATE_ONE : rate_interp;
        end
        pending_inc_d = phase_inc_we ? phase_inc : pending_inc_q;

        active_inc_d = active_inc_q;
        cic_cnt_d    = cic_cnt_q;
        prime_cnt_d  = prime_cnt_q;
        phase_d      = phase_q;
        hb_ph_d      = hb_ph_q;
        strobe_cic_d = 1'b0;
        strobe_bb_d  = 1'b0;

        if (!go) begin
            // Restart point: the first IF slot after priming begins feeds the CIC.
            active_inc_d = pending_inc_q;
            cic_cnt_d    = '0;
            prime_cnt_d  = '0;
            phase_d      = '0;
            hb_ph_d      = 1'b1;
        end else if (strobe_if) begin
            if (fire) begin
                cic_cnt_d    = eff_rate_next - RATE_ONE;
                strobe_cic_d = 1'b1;
                strobe_bb_d  = byp_hbf | hb_ph_q;
                hb_ph_d      = ~hb_ph_q;
            end else begin
                cic_cnt_d = cic_cnt_q - RATE_ONE;
            end
            phase_d      = phase_q + active_inc_q;
            active_inc_d = pending_inc_q;
            if (state_q == PRIME) begin
                prime_cnt_d = prime_cnt_q + 1'b1;
            end
        end

        underrun_d = aclr ? 1'b0 : (underrun_q | underrun_evt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_rate_q <= RATE_ONE;
            active_rate_q  <= RATE_ONE;
            cic_cnt_q      <= '0;
            pending_inc_q  <= '0;
            active_inc_q   <= '0;
            phase_q        <= '0;
            prime_cnt_q    <= '0;
            log2_rate_q    <= '0;
            hb_ph_q        <= 1'b1;
            strobe_cic_q   <= 1'b0;
            strobe_bb_q    <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            pending_rate_q <= pending_rate_d;
            active_rate_q  <= active_rate_d;
            cic_cnt_q      <= cic_cnt_d;
            pending_inc_q  <= pending_inc_d;
            active_inc_q   <= active_inc_d;
            phase_q        <= phase_d;
            prime_cnt_q    <= prime_cnt_d;
            log2_rate_q    <= log2_rate_d;
            hb_ph_q        <= hb_ph_d;
            strobe_cic_q   <= strobe_cic_d;
            strobe_bb_q    <= strobe_bb_d;
            underrun_q     <= underrun_d;
        end
    end

`ifdef WCA_DUC_UNDERRUN_CNT_EN
    logic [15:0] urun_cnt_q, urun_cnt_d;

    always_comb begin
        urun_cnt_d = urun_cnt_q;
        if (aclr) begin
            urun_cnt_d = '0;
        end else if (underrun_evt && (urun_cnt_q != 16'hFFFF)) begin
            urun_cnt_d = urun_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            urun_cnt_q <= '0;
        end else begin
            urun_cnt_q <= urun_cnt_d;
        end
    end

    assign underrun_cnt = urun_cnt_q;
`endif

    assign strobe_cic   = strobe_cic_q;
    assign strobe_bb    = strobe_bb_q;
    assign phase_cordic = phase_q;
    assign log2_rate    = log2_rate_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_wca_duc_sequencer.sv
// Scoreboard bench for wca_duc_sequencer: expected CIC/BB strobe times are queued
// as strobe_if is driven and retired by a per-cycle monitor.
module tb_wca_duc_sequencer;
    import wca_dduc_pkg::*;

    localparam int RATE_W = RATE_W_DEF;

    logic              clock;
    logic              reset;
    logic              enable;
    logic [7:0]        cfg;
    logic [RATE_W-1:0] rate_interp;
    logic              rate_interp_we;
    logic [31:0]       phase_inc;
    logic              phase_inc_we;
    logic              strobe_if;
    logic              bb_valid;
    logic              strobe_cic;
    logic              strobe_bb;
    logic [31:0]       phase_cordic;
    logic [3:0]        log2_rate;
    logic              running;
    logic              underrun;
`ifdef WCA_DUC_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    wca_duc_sequencer #(.PRIME_CYCLES(16), .RATE_W(RATE_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .cfg            (cfg),
        .rate_interp    (rate_interp),
        .rate_interp_we (rate_interp_we),
        .phase_inc      (phase_inc),
        .phase_inc_we   (phase_inc_we),
        .strobe_if      (strobe_if),
        .bb_valid       (bb_valid),
        .strobe_cic     (strobe_cic),
        .strobe_bb      (strobe_bb),
        .phase_cordic   (phase_cordic),
        .log2_rate      (log2_rate),
        .running        (running),
`ifdef WCA_DUC_UNDERRUN_CNT_EN
        .underrun       (underrun),
        .underrun_cnt   (underrun_cnt)
`else
        .underrun       (underrun)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int   cyc;
        logic bb;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          fire_plan[$];
    logic [31:0] exp_ph_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          strobe_idx = 0;
    int          n_fire  = 0;
    logic        hbf_byp = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // One clock; outputs are sampled 1ns after the edge and strobes retired.
    task automatic step_mon();
        sb_entry_t e;
        @(posedge clock);
        #1;
        if (strobe_cic === 1'b1) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_cic_unexpected cyc=%0d got strobe_cic=1 want 0", cyc);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc != cyc || strobe_bb !== e.bb) begin
                    n_fail++;
                    $display("FAIL strobe_cic_timing got cyc=%0d strobe_bb=%b want cyc=%0d strobe_bb=%b",
                             cyc, strobe_bb, e.cyc, e.bb);
                end
            end
        end else if (strobe_bb === 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_bb_alone cyc=%0d got strobe_bb=1 want 0", cyc);
        end
        while (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_cic_missing got none want cyc=%0d", sb_q[0].cyc);
            sb_q.delete(0);
        end
    endtask

    task automatic pulse_if();
        sb_entry_t e;
        strobe_if = 1'b1;
        if (fire_plan.size() != 0 && fire_plan[0] == strobe_idx) begin
            fire_plan.delete(0);
            e.cyc = cyc + 1;
            e.bb  = hbf_byp || ((n_fire % 2) == 0);
            sb_q.push_back(e);
            n_fire++;
        end
        strobe_idx++;
        step_mon();
        strobe_if = 1'b0;
    endtask

    task automatic drive_if(input int n, input int spacing);
        for (int k = 0; k < n; k++) begin
            pulse_if();
            repeat (spacing - 1) step_mon();
        end
    endtask

    task automatic plan_every(input int first, input int n, input int period);
        for (int i = 0; i < n; i++) fire_plan.push_back(first + i * period);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        step_mon();
        step_mon();
        n_fire     = 0;
        strobe_idx = 0;
        fire_plan.delete();
    endtask

    task automatic start_run();
        enable = 1'b1;
        step_mon();
    endtask

    task automatic write_rate(input logic [RATE_W-1:0] v);
        rate_interp    = v;
        rate_interp_we = 1'b1;
        step_mon();
        rate_interp_we = 1'b0;
    endtask

    task automatic write_inc(input logic [31:0] v);
        phase_inc    = v;
        phase_inc_we = 1'b1;
        step_mon();
        phase_inc_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; cfg = 8'h00; rate_interp = '0; rate_interp_we = 1'b0;
        phase_inc = '0; phase_inc_we = 1'b0; strobe_if = 1'b0; bb_valid = 1'b1;
        step_mon();
        step_mon();
        reset = 1'b0;
        n_tests++;
        if ({strobe_cic, strobe_bb, running, underrun} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000", {strobe_cic, strobe_bb, running, underrun});
        end
        n_tests++;
        if (phase_cordic !== 32'h0 || log2_rate !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_values got phase=%h log2=%0d want 0 0", phase_cordic, log2_rate);
        end
`ifdef WCA_DUC_UNDERRUN_CNT_EN
        n_tests++;
        if (underrun_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_ucnt got %0d want 0", underrun_cnt);
        end
`endif
    endtask

    task automatic test_rate4();
        go_idle();
        hbf_byp = 1'b0;
        write_rate(13'd4);
        start_run();
        n_tests++;
        if (log2_rate !== 4'd2) begin
            n_fail++;
            $display("FAIL rate4_log2 got %0d want 2", log2_rate);
        end
        plan_every(0, 6, 4);
        drive_if(15, 2);
        n_tests++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL prime_15 got running=%b want 0", running);
        end
        pulse_if();
        n_tests++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL prime_16 got running=%b want 1", running);
        end
        step_mon();
        drive_if(8, 2);
        step_mon();
    endtask

    task automatic test_rate_change();
        go_idle();
        start_run();
        fire_plan = '{0, 4, 8, 16, 24};
        drive_if(6, 2);
        write_rate(13'd8);
        drive_if(2, 2);
        n_tests++;
        if (log2_rate !== 4'd2) begin
            n_fail++;
            $display("FAIL ratechg_before got log2=%0d want 2", log2_rate);
        end
        pulse_if();
        n_tests++;
        if (log2_rate !== 4'd3) begin
            n_fail++;
            $display("FAIL ratechg_boundary got log2=%0d want 3", log2_rate);
        end
        step_mon();
        drive_if(17, 2);
        step_mon();
    endtask

    task automatic test_phase();
        logic [31:0] exp_tab [6];
        logic [31:0] want;
        exp_tab = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000,
                    32'h0000_0000, 32'h4000_0000, 32'h4000_0001};
        go_idle();
        write_inc(32'h4000_0000);
        start_run();
        n_tests++;
        if (phase_cordic !== 32'h0) begin
            n_fail++;
            $display("FAIL phase_start got %h want 0", phase_cordic);
        end
        fire_plan = '{0};
        for (int k = 0; k < 6; k++) begin
            if (k == 4) write_inc(32'h0000_0001);
            exp_ph_q.push_back(exp_tab[k]);
            pulse_if();
            want = exp_ph_q.pop_front();
            n_tests++;
            if (phase_cordic !== want) begin
                n_fail++;
                $display("FAIL phase_step%0d got %h want %h", k, phase_cordic, want);
            end
            step_mon();
        end
    endtask

    task automatic test_bypass();
        go_idle();
        cfg = 8'h28;
        hbf_byp = 1'b1;
        write_rate(13'd100);
        start_run();
        n_tests++;
        if (log2_rate !== 4'd0) begin
            n_fail++;
            $display("FAIL bypass_log2 got %0d want 0", log2_rate);
        end
        plan_every(0, 6, 1);
        drive_if(3, 1);
        drive_if(3, 3);
        go_idle();
        cfg = 8'h00;
        hbf_byp = 1'b0;
        step_mon();
        n_tests++;
        if (log2_rate !== 4'd6) begin
            n_fail++;
            $display("FAIL rate100_log2 got %0d want 6", log2_rate);
        end
        write_rate(13'd0);
        step_mon();
        n_tests++;
        if (log2_rate !== 4'd0) begin
            n_fail++;
            $display("FAIL rate0_log2 got %0d want 0", log2_rate);
        end
        start_run();
        plan_every(0, 3, 1);
        drive_if(3, 2);
        go_idle();
        write_rate(13'd8191);
        step_mon();
        n_tests++;
        if (log2_rate !== 4'd12) begin
            n_fail++;
            $display("FAIL rate8191_log2 got %0d want 12", log2_rate);
        end
    endtask

    task automatic test_underrun();
        go_idle();
        write_rate(13'd1);
        write_inc(32'h0000_0010);
        bb_valid = 1'b0;
        start_run();
        plan_every(0, 40, 1);
        drive_if(16, 2);
        n_tests++;
        if (underrun !== 1'b0 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL urun_prime_ignored got underrun=%b running=%b want 0 1", underrun, running);
        end
        bb_valid = 1'b1;
        drive_if(2, 2);
        bb_valid = 1'b0;
        drive_if(1, 2);
        bb_valid = 1'b1;
        n_tests++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL urun_set got %b want 1", underrun);
        end
`ifdef WCA_DUC_UNDERRUN_CNT_EN
        n_tests++;
        if (underrun_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL urun_cnt_one got %0d want 1", underrun_cnt);
        end
`endif
        drive_if(4, 2);
        n_tests++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL urun_sticky got %b want 1", underrun);
        end
        cfg = 8'h02;
        step_mon();
        cfg = 8'h00;
        n_fire     = 0;
        strobe_idx = 0;
        fire_plan.delete();
        n_tests++;
        if (underrun !== 1'b0 || running !== 1'b0 || phase_cordic !== 32'h0) begin
            n_fail++;
            $display("FAIL aclr got underrun=%b running=%b phase=%h want 0 0 0", underrun, running, phase_cordic);
        end
`ifdef WCA_DUC_UNDERRUN_CNT_EN
        n_tests++;
        if (underrun_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL urun_cnt_clear got %0d want 0", underrun_cnt);
        end
`endif
        step_mon();
        fire_plan = '{0};
        pulse_if();
        n_tests++;
        if (phase_cordic !== 32'h0000_0010 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL aclr_pending_kept got phase=%h running=%b want 00000010 0", phase_cordic, running);
        end
        step_mon();
    endtask

    task automatic test_abort();
        go_idle();
        write_rate(13'd2);
        write_inc(32'h0000_0100);
        start_run();
        plan_every(0, 3, 2);
        drive_if(6, 2);
        enable    = 1'b0;
        strobe_if = 1'b1;
        step_mon();
        strobe_if = 1'b0;
        n_tests++;
        if (strobe_cic !== 1'b0 || running !== 1'b0 || phase_cordic !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_prime got cic=%b running=%b phase=%h want 0 0 0", strobe_cic, running, phase_cordic);
        end
        n_fire     = 0;
        strobe_idx = 0;
        start_run();
        plan_every(0, 9, 2);
        drive_if(17, 2);
        n_tests++;
        if (running !== 1'b1 || phase_cordic !== 32'h0000_1100) begin
            n_fail++;
            $display("FAIL abort_run_state got running=%b phase=%h want 1 00001100", running, phase_cordic);
        end
        write_rate(13'd8);
        reset     = 1'b1;
        strobe_if = 1'b1;
        step_mon();
        strobe_if = 1'b0;
        n_tests++;
        if ({strobe_cic, strobe_bb, running, underrun} !== 4'b0000 ||
            phase_cordic !== 32'h0 || log2_rate !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_in_run got flags=%b phase=%h log2=%0d want 0000 0 0",
                     {strobe_cic, strobe_bb, running, underrun}, phase_cordic, log2_rate);
        end
        reset  = 1'b0;
        enable = 1'b0;
        step_mon();
        n_tests++;
        if (log2_rate !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_pending_rate got log2=%0d want 0", log2_rate);
        end
    endtask

    initial begin
        test_reset();
        test_rate4();
        test_rate_change();
        test_phase();
        test_bypass();
        test_underrun();
        test_abort();
        step_mon();
        step_mon();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
